serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract sequencer built around one half-adder-pair full-add cell (sum = a^b^c, carry = ab | c(a^b)).
- Latches two WIDTH-bit operands on a start request and feeds the adder cell one bit per clock, LSB first.
- Collects the result in a shift register and presents it through a done/ack handshake.
- Serves as the area-minimal arithmetic unit for small control datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation; sampled only in IDLE
- sub  input  1  0 = A+B, 1 = A-B; sampled with start
- op_a  input  WIDTH  operand A; sampled with start
- op_b  input  WIDTH  operand B; sampled with start
- ack  input  1  consumer has taken the result; sampled only in DONE
- busy  output  1  high in RUN and DONE
- done  output  1  high in DONE only; result valid
- result  output  WIDTH  A+B or A-B modulo 2^WIDTH
- carry_out  output  1  final carry; for subtract, 1 = no borrow
- overflow  output  1  two's-complement overflow (carry into MSB xor carry out of MSB)

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, bit counter=0, carry reg=0, operand shift regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on a clk edge with start=1.
  - At that edge: shift_a<=op_a; shift_b<=op_b if sub=0, else ~op_b; carry<=sub; count<=0.
- RUN: each edge processes one bit.
  - a_bit=shift_a[0], b_bit=shift_b[0].
  - Compute the sum and next carry through the half-adder pair.
  - result <= {sum, result[WIDTH-1:1]}; shift_a and shift_b shift right; carry<=next carry; count<=count+1.
  - When count==WIDTH-1, the carry into the cell is latched as c_msb_in.
  - On the edge processing bit WIDTH-1: state<=DONE, carry_out<=next carry, overflow<=c_msb_in ^ next carry.
- Latency: start accepted at edge k; done=1 after edge k+WIDTH (exactly WIDTH RUN cycles).
- DONE:
  - done=1 and busy=1; result, carry_out and overflow are held stable.
  - On an edge with ack=1: state<=IDLE, done<=0. result, carry_out and overflow keep their values until the next operation starts.
  - DONE has no timeout; it is held indefinitely until ack.
- Ignored inputs:
  - start in RUN or DONE is ignored; op_a, op_b and sub changes during RUN have no effect.
  - ack outside DONE is ignored.
- ack and start both high in DONE: ack is honoured (-> IDLE); start is ignored. A new start is needed in IDLE (minimum one IDLE cycle between operations).
- Counter width: clog2(WIDTH)+1 bits; no wrap-around beyond WIDTH.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted, all outputs return to reset values immediately, and there is no partial result.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan (WIDTH=8):
- Add: op_a=0x3C, op_b=0x05, sub=0, start pulse -> done rises exactly 8 clocks later; result=0x41, carry_out=0, overflow=0; busy high for the 8 RUN cycles and through DONE.
- Unsigned wrap and signed overflow:
  - 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0.
  - 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
- Subtract:
  - 0x05-0x07 (sub=1) -> result=0xFE, carry_out=0 (borrow), overflow=0.
  - 0x80-0x01 -> result=0x7F, carry_out=1, overflow=1.
- Handshake: hold ack low 5 cycles after done -> result and done stable; ack=1 with start=1 at the same edge -> IDLE, no new operation; start next cycle -> new operation begins.
- Ignored start: pulse start with different operands on RUN cycle 3 -> result unaffected (first operation's value), done timing unchanged.
- Reset mid-operation: deassert rst_n asynchronously (between clock edges) during RUN cycle 4 -> busy, done, result, carry_out and overflow go to 0 immediately; after release, a fresh 0x3C+0x05 completes correctly.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract sequencer: one full-add cell processes a WIDTH-bit operand pair
// LSB first, then holds the result under a done/ack handshake.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    shift_a_q, shift_a_d;
    logic [WIDTH-1:0]    shift_b_q, shift_b_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                carry_q, carry_d;
    logic                carry_out_q, carry_out_d;
    logic                overflow_q, overflow_d;

    // Full-add cell built from two half adders.
    logic ha1_sum, ha1_carry, ha2_carry, cell_sum, cell_carry;
    logic c_msb_in;
    logic last_bit;

    assign ha1_sum    = shift_a_q[0] ^ shift_b_q[0];
    assign ha1_carry  = shift_a_q[0] & shift_b_q[0];
    assign cell_sum   = ha1_sum ^ carry_q;
    assign ha2_carry  = ha1_sum & carry_q;
    assign cell_carry = ha1_carry | ha2_carry;

    assign last_bit = (count_q == CntW'(WIDTH - 1));
    // On the MSB cycle the carry register holds the carry into the MSB.
    assign c_msb_in = carry_q;

    always_comb begin
        state_d     = state_q;
        shift_a_d   = shift_a_q;
        shift_b_d   = shift_b_q;
        result_d    = result_q;
        count_d     = count_q;
        carry_d     = carry_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StRun;
                    shift_a_d = op_a;
                    // Subtraction as A + ~B + 1: invert B and seed the carry.
                    shift_b_d = sub ? ~op_b : op_b;
                    carry_d   = sub;
                    count_d   = '0;
                end
            end
            StRun: begin
                result_d  = {cell_sum, result_q[WIDTH-1:1]};
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                carry_d   = cell_carry;
                count_d   = count_q + CntW'(1);
                if (last_bit) begin
                    state_d     = StDone;
                    carry_out_d = cell_carry;
                    overflow_d  = c_msb_in ^ cell_carry;
                end
            end
            StDone: begin
                if (ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            shift_a_q   <= '0;
            shift_b_q   <= '0;
            result_q    <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_a_q   <= shift_a_d;
            shift_b_q   <= shift_b_d;
            result_q    <= result_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: directed test-plan cases then randomized operations
// checked against an arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         ack = 1'b0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .op_a     (op_a),
        .op_b     (op_b),
        .ack      (ack),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry_out(carry_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: A+B or A+~B+1 in W+1 bits; overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t        e;
        logic [W:0]  full;
        logic [W-1:0] bb;
        bb = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        e.r = full[W-1:0];
        e.c = full[W];
        if (s) e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
        else   e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        return e;
    endfunction

    // Monitor: pops on each rising done, then checks stability while done stays high.
    exp_t held;
    logic done_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_prev = 1'b0;
            end else begin
                if (done && !done_prev) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        held = sb.pop_front();
                        chk("result", {24'd0, result}, {24'd0, held.r});
                        chk("carry_out", {31'd0, carry_out}, {31'd0, held.c});
                        chk("overflow", {31'd0, overflow}, {31'd0, held.v});
                    end
                end else if (done && done_prev) begin
                    chk("hold_stable", {23'd0, result, carry_out}, {23'd0, held.r, held.c});
                end
                done_prev = done;
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int hold, input bit glitch, input bit ack_start);
        int   cyc;
        exp_t e;
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; sub = s;
        e = model(a, b, s);
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // Operand changes during RUN must have no effect.
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom);
        cyc = 0;
        while (!done && cyc < W + 4) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            if (glitch && cyc == 3) begin
                start = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, W);
        chk("busy_done", {31'd0, busy}, 32'd1);
        repeat (hold) @(negedge clk);
        chk("done_held", {31'd0, done}, 32'd1);
        ack = 1'b1;
        if (ack_start) begin
            start = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
        end
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        chk("idle_after_ack", {30'd0, busy, done}, 32'd0);
        chk("result_kept", {24'd0, result}, {24'd0, e.r});
        if (ack_start) begin
            @(negedge clk);
            chk("no_op_from_ack_start", {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        start = 1'b1; op_a = 8'h3C; op_b = 8'h05; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {20'd0, busy, done, result, carry_out, overflow}, 32'd0);
        @(negedge clk);
        chk("rst_mid_held", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        chk("reset_outputs", {20'd0, busy, done, result, carry_out, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

        run_op(8'h3C, 8'h05, 1'b0, 0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 2, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 0, 1'b0, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 5, 1'b0, 1'b1);
        run_op(8'hA5, 8'h5A, 1'b1, 0, 1'b1, 1'b0);
        reset_mid_run();
        run_op(8'h3C, 8'h05, 1'b0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 5)),
                   1'($urandom), 1'($urandom));
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
